// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control slice.
package pipe_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned PC_REG = 15;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_STALL,
    ST_MEM_WAIT
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Single source/destination comparator. The PC is never treated as a
// forwardable or stallable producer because its value comes from the fetch path.
module hazard_match #(
  parameter int unsigned PC_REG = pipe_pkg::PC_REG
) (
  input  logic [pipe_pkg::REG_W-1:0] src,
  input  logic                       src_used,
  input  logic [pipe_pkg::REG_W-1:0] rd,
  input  logic                       rd_wb,
  output logic                       match
);
  import pipe_pkg::*;

  localparam logic [REG_W-1:0] PC_IDX = PC_REG[REG_W-1:0];

  assign match = src_used && rd_wb && (src == rd) && (rd != PC_IDX);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / forwarding controller for the IF-ID-EX-MEM-WB pipeline.
// Enables and flushes are combinational; forwarding selects, stage trackers,
// the FSM and the statistics counters are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned PC_REG      = pipe_pkg::PC_REG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [pipe_pkg::REG_W-1:0] id_rn,
  input  logic [pipe_pkg::REG_W-1:0] id_rm,
  input  logic                       id_uses_rn,
  input  logic                       id_uses_rm,
  input  logic [pipe_pkg::REG_W-1:0] ex_rd,
  input  logic                       ex_wb_en,
  input  logic                       ex_is_load,
  input  logic                       ex_branch_taken,
  input  logic                       mem_req,
  input  logic                       mem_ready,
  output logic                       if_en,
  output logic                       id_ex_en,
  output logic                       ex_mem_en,
  output logic                       mem_wb_en,
  output logic                       if_id_flush,
  output logic                       id_ex_flush,
  output logic [1:0]                 fwd_a_sel,
  output logic [1:0]                 fwd_b_sel,
  output logic [CNT_W-1:0]           stall_count,
  output logic                       mem_timeout
);
  import pipe_pkg::*;

  localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e          state_q, state_d;
  logic [REG_W-1:0]   mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic               mem_wb_q, mem_wb_d, mem_load_q, mem_load_d;
  logic               wb_wb_q, wb_wb_d;
  logic [1:0]         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;

  logic rn_ex_hit, rm_ex_hit, rn_mem_hit, rm_mem_hit;
  logic freeze, lu_hazard, lu_stall;
  logic [1:0] fwd_a_calc, fwd_b_calc;
  logic unused_trk;

  hazard_match #(.PC_REG(PC_REG)) u_rn_ex  (.src(id_rn), .src_used(id_uses_rn),
    .rd(ex_rd),    .rd_wb(ex_wb_en), .match(rn_ex_hit));
  hazard_match #(.PC_REG(PC_REG)) u_rm_ex  (.src(id_rm), .src_used(id_uses_rm),
    .rd(ex_rd),    .rd_wb(ex_wb_en), .match(rm_ex_hit));
  hazard_match #(.PC_REG(PC_REG)) u_rn_mem (.src(id_rn), .src_used(id_uses_rn),
    .rd(mem_rd_q), .rd_wb(mem_wb_q), .match(rn_mem_hit));
  hazard_match #(.PC_REG(PC_REG)) u_rm_mem (.src(id_rm), .src_used(id_uses_rm),
    .rd(mem_rd_q), .rd_wb(mem_wb_q), .match(rm_mem_hit));

  // The WB mirror and MEM load flag are kept for visibility only
  assign unused_trk = ^{wb_rd_q, wb_wb_q, mem_load_q};

  // Hazard classification; a load-use bubble is only inserted once per load
  always_comb begin
    freeze    = mem_req & ~mem_ready;
    lu_hazard = id_valid & ex_is_load & (rn_ex_hit | rm_ex_hit)
                & (state_q != ST_LU_STALL);
    lu_stall  = ~reset & ~freeze & ~ex_branch_taken & lu_hazard;
  end

  // Pipeline-register enables and bubble injection
  always_comb begin
    if_en       = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!reset && !freeze) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_branch_taken) begin
        if_en       = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_hazard) begin
        id_ex_flush = 1'b1;
      end else begin
        if_en = 1'b1;
      end
    end
  end

  // Forwarding selects: the EX producer is younger than MEM and wins
  always_comb begin
    fwd_a_calc = FWD_RF;
    fwd_b_calc = FWD_RF;
    if (rn_ex_hit && !ex_is_load) fwd_a_calc = FWD_EXMEM;
    else if (rn_mem_hit)          fwd_a_calc = FWD_MEMWB;
    if (rm_ex_hit && !ex_is_load) fwd_b_calc = FWD_EXMEM;
    else if (rm_mem_hit)          fwd_b_calc = FWD_MEMWB;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (id_ex_en) begin
      fwd_a_d = id_ex_flush ? FWD_RF : fwd_a_calc;
      fwd_b_d = id_ex_flush ? FWD_RF : fwd_b_calc;
    end
  end

  // MEM / WB destination trackers follow the real pipeline registers
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_wb_d   = mem_wb_q;
    mem_load_d = mem_load_q;
    wb_rd_d    = wb_rd_q;
    wb_wb_d    = wb_wb_q;
    if (ex_mem_en) begin
      mem_rd_d   = ex_rd;
      mem_wb_d   = ex_wb_en;
      mem_load_d = ex_is_load;
    end
    if (mem_wb_en) begin
      wb_rd_d = mem_rd_q;
      wb_wb_d = mem_wb_q;
    end
  end

  // FSM next state plus wait-timeout and stall statistics
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      ST_RUN:      if (freeze) state_d = ST_MEM_WAIT;
                   else if (lu_stall) state_d = ST_LU_STALL;
      ST_LU_STALL: state_d = freeze ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: if (mem_ready) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    if (state_q != ST_MEM_WAIT && state_d == ST_MEM_WAIT) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_MEM_WAIT && !mem_ready && wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
    if (!if_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      mem_rd_q    <= '0;
      mem_wb_q    <= 1'b0;
      mem_load_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_wb_q     <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_wb_q    <= mem_wb_d;
      mem_load_q  <= mem_load_d;
      wb_rd_q     <= wb_rd_d;
      wb_wb_q     <= wb_wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = stall_cnt_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_rn, id_uses_rm;
  logic [3:0]       id_rn, id_rm, ex_rd;
  logic             ex_wb_en, ex_is_load, ex_branch_taken, mem_req, mem_ready;
  logic             if_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout;
  logic [5:0]       ctl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .PC_REG(15)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_en(if_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  // {if_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  assign ctl = {if_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0;
    ex_rd = 0; ex_wb_en = 0; ex_is_load = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_ex(input logic [3:0] rd, input logic wb, input logic ld);
    ex_rd = rd; ex_wb_en = wb; ex_is_load = ld;
  endtask

  task automatic set_id(input logic [3:0] rn, input logic urn,
                        input logic [3:0] rm, input logic urm);
    id_valid = 1; id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
  endtask

  initial begin
    // Reset with a branch and a freeze pending: nothing may be enabled or flushed
    idle();
    reset = 1; ex_branch_taken = 1; mem_req = 1;
    settle();
    check("reset_ctl_freeze", ctl, 6'b000000);
    mem_req = 0;
    settle();
    check("reset_ctl_branch", ctl, 6'b000000);
    tick();
    tick();
    check("reset_fwd_a", fwd_a_sel, 2'b00);
    check("reset_fwd_b", fwd_b_sel, 2'b00);
    check("reset_stall", stall_count, 0);
    check("reset_timeout", mem_timeout, 0);

    reset = 0; idle();
    settle();
    check("run_ctl", ctl, 6'b111100);
    tick();

    // ADD r1 in EX, ID reads r1 -> EX/MEM forward, no stall
    set_ex(4'd1, 1, 0); set_id(4'd1, 1, 4'd0, 0);
    settle();
    check("add_ctl", ctl, 6'b111100);
    tick();
    check("add_fwd_a", fwd_a_sel, 2'b01);
    check("add_fwd_b", fwd_b_sel, 2'b00);
    check("add_stall", stall_count, 0);
    idle();
    tick();

    // LDR r2 in EX, ID reads r2 on rm -> one bubble
    set_ex(4'd2, 1, 1); set_id(4'd0, 0, 4'd2, 1);
    settle();
    check("lu_ctl", ctl, 6'b011101);
    tick();
    check("lu_stall_cnt", stall_count, 1);
    check("lu_fwd_b_bubble", fwd_b_sel, 2'b00);
    set_ex(4'd0, 0, 0);
    settle();
    check("lu_resume_ctl", ctl, 6'b111100);
    tick();
    check("lu_fwd_b_mem", fwd_b_sel, 2'b10);
    check("lu_stall_hold", stall_count, 1);
    idle();

    // Younger producer wins: r3 in both EX and MEM
    set_ex(4'd3, 1, 0);
    tick();
    set_ex(4'd3, 1, 0); set_id(4'd3, 1, 4'd3, 1);
    tick();
    check("young_fwd_a", fwd_a_sel, 2'b01);
    check("young_fwd_b", fwd_b_sel, 2'b01);
    set_ex(4'd0, 0, 0);
    tick();
    check("old_fwd_a", fwd_a_sel, 2'b10);
    idle();
    tick();

    // Branch overrides a simultaneous load-use stall
    set_ex(4'd4, 1, 1); ex_branch_taken = 1; set_id(4'd4, 1, 4'd0, 0);
    settle();
    check("br_lu_ctl", ctl, 6'b111111);
    tick();
    check("br_lu_stall", stall_count, 1);
    check("br_lu_fwd_a", fwd_a_sel, 2'b00);
    idle();

    // Freeze with a branch held in EX for three cycles
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
      settle();
      check("frz_ctl", ctl, 6'b000000);
      tick();
    end
    check("frz_stall", stall_count, 3);
    mem_ready = 1;
    settle();
    check("frz_release_ctl", ctl, 6'b111111);
    tick();
    check("frz_stall_after", stall_count, 3);
    idle();
    tick();

    // Wait timeout with MEM_TIMEOUT=4, ready held low for 6 cycles
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 4) check("to_before", mem_timeout, 0);
      if (i == 5) check("to_rise", mem_timeout, 1);
    end
    check("to_stall6", stall_count, 9);
    mem_ready = 1;
    tick();
    idle();
    tick();
    check("to_sticky", mem_timeout, 1);

    // Stall counter saturates at all-ones (already at 9)
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 6; i++) tick();
    check("sat_reach", stall_count, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", stall_count, 15);
    check("sat_to_sticky", mem_timeout, 1);

    // Reset while frozen with a branch: no flush pulse on the reset cycle
    ex_branch_taken = 1;
    tick();
    reset = 1; mem_ready = 1;
    settle();
    check("rst_mid_ctl", ctl, 6'b000000);
    tick();
    check("rst_mid_stall", stall_count, 0);
    check("rst_mid_timeout", mem_timeout, 0);
    reset = 0; idle();
    settle();
    check("rst_mid_run", ctl, 6'b111100);
    tick();

    // PC as destination is never a hazard nor a forward source
    set_ex(4'd15, 1, 1); set_id(4'd15, 1, 4'd0, 0);
    settle();
    check("pc_ctl", ctl, 6'b111100);
    tick();
    check("pc_fwd_a_ex", fwd_a_sel, 2'b00);
    set_ex(4'd0, 0, 0);
    tick();
    check("pc_fwd_a_mem", fwd_a_sel, 2'b00);
    check("pc_stall", stall_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall, flush and forwarding controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Internally mirrors the rd/writeback-enable tags of the MEM and WB stages.
- Detects load-use hazards, taken branches and multi-cycle data-memory waits.
- Produces registered forwarding selects aligned with the EX stage, and keeps stall statistics.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before mem_timeout is raised
PC_REG, 15, register index excluded from hazard and forwarding checks

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rn  in  4  ID first source register
id_rm  in  4  ID second source register
id_uses_rn  in  1  id_rn is read
id_uses_rm  in  1  id_rm is read
ex_rd  in  4  destination register of the EX instruction
ex_wb_en  in  1  EX instruction writes back
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX branch resolved taken
mem_req  in  1  MEM instruction accesses data memory
mem_ready  in  1  data memory completes this cycle
if_en  out  1  PC and IF/ID enable
id_ex_en  out  1  ID/EX enable
ex_mem_en  out  1  EX/MEM enable
mem_wb_en  out  1  MEM/WB enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
fwd_a_sel  out  2  EX operand A source: 00 register file, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  same encoding, operand B
stall_count  out  CNT_W  saturating count of stalled cycles
mem_timeout  out  1  sticky error flag

Behaviour:
- Reset: clk and reset are as listed in Ports; reset is synchronous, active-high.
  - While reset is high: all enables 0, flushes 0, fwd sels 00, stall_count 0, mem_timeout 0, FSM in RUN, trackers cleared (rd 0, wb 0, load 0).
- Enables and flushes are combinational from inputs, tracker state and FSM state (zero latency). fwd sels, trackers and counters are registered.
- Trackers:
  - On ex_mem_en: mem_{rd,wb,load} <= ex_{rd,wb_en,is_load}.
  - On mem_wb_en: wb_{rd,wb} <= mem_{rd,wb}.
  - A flush writes wb=0 into the tracker of the flushed stage.
- Hazard match: src==rd AND producer wb AND used AND rd!=PC_REG.
- freeze = mem_req & !mem_ready.
  - All four enables are 0 and no flush is issued.
  - WB holds; the repeated register-file write is idempotent.
- Load-use stall (no freeze, no branch, id_valid, match against EX with ex_is_load):
  - if_en=0 and id_ex_flush=1.
  - ex_mem_en=1 and mem_wb_en=1.
  - Lasts exactly one cycle; the next cycle resolves through forwarding.
- Branch (no freeze, ex_branch_taken):
  - if_id_flush=1, id_ex_flush=1, all enables 1.
  - Overrides a simultaneous load-use stall.
  - A branch arriving during a freeze is held in EX and flushed in the first unfrozen cycle.
- Normal operation: all enables 1, flushes 0.
- Forwarding, computed from ID inputs and registered when id_ex_en=1:
  - Match against EX (non-load) gives 01.
  - Otherwise, match against the MEM tracker gives 10.
  - Otherwise 00. The younger producer wins.
  - When id_ex_flush=1, fwd sels register 00.
- FSM states: RUN, LU_STALL, MEM_WAIT.
  - RUN -> MEM_WAIT on freeze.
  - RUN -> LU_STALL on a load-use stall.
  - LU_STALL -> RUN unconditionally; LU_STALL -> MEM_WAIT if freeze.
  - MEM_WAIT -> RUN when mem_ready.
  - The wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset. The FSM still waits.
- stall_count increments on every cycle with if_en=0 and reset low, and saturates at all-ones.
- Reset mid-freeze or mid-stall: outputs return to reset values in the next cycle and no flush pulse is emitted.

Decomposition:
- Shared package pipe_pkg: fwd-select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB), FSM state enum, register-width constant (4), PC_REG.
- One sub-module, hazard_match: combinational src/rd/wb/use/PC comparator, instantiated four times (rn/rm against EX and MEM).

Test Plan:
- ADD r1 in EX (ex_rd=1, wb=1); ID uses rn=1 -> no stall; next cycle fwd_a_sel=01, all enables 1.
- LDR r2 in EX (is_load=1); ID uses rm=2 -> one cycle with if_en=0, id_ex_flush=1, stall_count=1; next cycle fwd_b_sel=10 and FSM back in RUN.
- ex_branch_taken=1 together with a load-use condition -> if_id_flush=1, id_ex_flush=1, if_en=1, stall_count unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, branch taken in EX -> all enables 0 and no flush for 3 cycles; flushes pulse in the cycle mem_ready=1; stall_count=3.
- MEM_TIMEOUT=4 with mem_ready held 0 for 6 cycles -> mem_timeout rises after 4 waiting cycles and stays 1 after mem_ready until reset.
- ex_rd=15 with wb=1 and ID rn=15 -> fwd_a_sel=00 and no stall.
